// File: rtl/deserializer.sv
// Serial-to-parallel receiver: rebuilds MSB-first frames delimited by a strobe,
// delivering good frames with their bit count and flagging short or overlong ones.
module deserializer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MIN_LEN = 3,
  localparam int unsigned MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = MOD_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                armed_q, armed_d;
  logic [MOD_W-1:0]    bit_idx;

  // Write position for the next bit; only used while cnt_q < DATA_W.
  assign bit_idx = MOD_W'(DATA_W - 1) - cnt_q[MOD_W-1:0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    // A strobe already high out of reset must drop before a frame is accepted.
    armed_d = armed_q | ~ser_data_val_i;

    unique case (state_q)
      IDLE: begin
        if (ser_data_val_i && armed_q) begin
          sh_d           = '0;
          sh_d[DATA_W-1] = ser_data_i;
          cnt_d          = CNT_W'(1);
          state_d        = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            state_d = DROP;
          end else begin
            sh_d[bit_idx] = ser_data_i;
            cnt_d         = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q >= CNT_W'(MIN_LEN)) begin
            data_d = sh_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!ser_data_val_i) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Busy spans the frame plus the cycle its result or error is presented.
    busy_d = (state_d != IDLE) || (state_q != IDLE);
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign err_o            = err_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: reset, good/short/overlong frames,
// back-to-back frames and mid-frame reset recovery.
module tb_deserializer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned MOD_W  = 4;

  logic              clk_i;
  logic              arst_n_i;
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              err_o;
  logic              busy_o;

  int checks;
  int errors;
  int val_cnt;
  int err_cnt;
  int busy_cnt;
  int both_cnt;
  logic [DATA_W-1:0] cap_data [4];
  logic [MOD_W-1:0]  cap_mod  [4];

  deserializer #(.DATA_W(DATA_W), .MIN_LEN(3)) dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .err_o            (err_o),
    .busy_o           (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Pulse/busy observer on the falling edge.
  always @(negedge clk_i) begin
    if (deser_data_val_o) begin
      if (val_cnt < 4) begin
        cap_data[val_cnt] = deser_data_o;
        cap_mod[val_cnt]  = deser_data_mod_o;
      end
      val_cnt = val_cnt + 1;
    end
    if (err_o) err_cnt = err_cnt + 1;
    if (busy_o) busy_cnt = busy_cnt + 1;
    if (deser_data_val_o && err_o) both_cnt = both_cnt + 1;
  end

  task automatic clear_counts();
    val_cnt  = 0;
    err_cnt  = 0;
    busy_cnt = 0;
  endtask

  // Drives n bits MSB-first from bits, then drops the strobe; returns at the
  // falling edge where the strobe was lowered.
  task automatic send_frame(input logic [31:0] bits, input int n);
    logic [31:0] b;
    b = bits;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      ser_data_val_i = 1'b1;
      ser_data_i     = b[n-1-i];
    end
    @(negedge clk_i);
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
  endtask

  task automatic test_reset();
    arst_n_i       = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (deser_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd0) begin errors++; $display("FAIL reset_mod got %0d exp 0", deser_data_mod_o); end
    checks++; if (deser_data_val_o !== 1'b0) begin errors++; $display("FAIL reset_val got %b exp 0", deser_data_val_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    arst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_full_frame();
    clear_counts();
    send_frame(32'h0000_A5C3, 16);
    @(negedge clk_i);
    checks++; if (deser_data_val_o !== 1'b1) begin errors++; $display("FAIL full_val got %b exp 1", deser_data_val_o); end
    checks++; if (deser_data_o !== 16'hA5C3) begin errors++; $display("FAIL full_data got %h exp a5c3", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd0) begin errors++; $display("FAIL full_mod got %0d exp 0", deser_data_mod_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err got %b exp 0", err_o); end
    @(negedge clk_i);
    checks++; if (deser_data_val_o !== 1'b0) begin errors++; $display("FAIL full_val_end got %b exp 0", deser_data_val_o); end
    checks++; if (val_cnt !== 1) begin errors++; $display("FAIL full_pulses got %0d exp 1", val_cnt); end
  endtask

  task automatic test_short_good();
    clear_counts();
    send_frame(32'b10110, 5);
    @(negedge clk_i);
    checks++; if (deser_data_o !== 16'hB000) begin errors++; $display("FAIL five_data got %h exp b000", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd5) begin errors++; $display("FAIL five_mod got %0d exp 5", deser_data_mod_o); end
    repeat (3) @(negedge clk_i);
    checks++; if (val_cnt !== 1) begin errors++; $display("FAIL five_pulses got %0d exp 1", val_cnt); end
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL five_busy got %0d exp 6", busy_cnt); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL five_busy_end got %b exp 0", busy_o); end
  endtask

  task automatic test_too_short();
    clear_counts();
    send_frame(32'b11, 2);
    @(negedge clk_i);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", err_o); end
    @(negedge clk_i);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL short_err_end got %b exp 0", err_o); end
    checks++; if (val_cnt !== 0) begin errors++; $display("FAIL short_val got %0d exp 0", val_cnt); end
    checks++; if (deser_data_o !== 16'hB000) begin errors++; $display("FAIL short_hold_data got %h exp b000", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd5) begin errors++; $display("FAIL short_hold_mod got %0d exp 5", deser_data_mod_o); end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_frame(32'h0002_5A5A, 18);
    @(negedge clk_i);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err_o); end
    @(negedge clk_i);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL ovf_err_cnt got %0d exp 1", err_cnt); end
    checks++; if (val_cnt !== 0) begin errors++; $display("FAIL ovf_val got %0d exp 0", val_cnt); end
    checks++; if (deser_data_o !== 16'hB000) begin errors++; $display("FAIL ovf_hold_data got %h exp b000", deser_data_o); end
    send_frame(32'b111, 3);
    @(negedge clk_i);
    checks++; if (deser_data_val_o !== 1'b1) begin errors++; $display("FAIL ovf_next_val got %b exp 1", deser_data_val_o); end
    checks++; if (deser_data_o !== 16'hE000) begin errors++; $display("FAIL ovf_next_data got %h exp e000", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd3) begin errors++; $display("FAIL ovf_next_mod got %0d exp 3", deser_data_mod_o); end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] d;
    clear_counts();
    v = 8'b1110_1111;
    d = 8'b1010_0110;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_i);
      ser_data_val_i = v[i];
      ser_data_i     = d[i];
    end
    @(negedge clk_i);
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (val_cnt !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", val_cnt); end
    checks++; if (cap_data[0] !== 16'hA000) begin errors++; $display("FAIL b2b_data0 got %h exp a000", cap_data[0]); end
    checks++; if (cap_mod[0] !== 4'd3) begin errors++; $display("FAIL b2b_mod0 got %0d exp 3", cap_mod[0]); end
    checks++; if (cap_data[1] !== 16'h6000) begin errors++; $display("FAIL b2b_data1 got %h exp 6000", cap_data[1]); end
    checks++; if (cap_mod[1] !== 4'd4) begin errors++; $display("FAIL b2b_mod1 got %0d exp 4", cap_mod[1]); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      ser_data_val_i = 1'b1;
      ser_data_i     = 1'b1;
    end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", busy_o); end
    #2 arst_n_i = 1'b0;
    #1;
    checks++; if (deser_data_o !== 16'h0000) begin errors++; $display("FAIL mid_rst_data got %h exp 0000", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd0) begin errors++; $display("FAIL mid_rst_mod got %0d exp 0", deser_data_mod_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy_o); end
    @(negedge clk_i);
    #2 arst_n_i = 1'b1;
    // Strobe stays high for the rest of the aborted frame.
    repeat (5) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_ignore_busy got %b exp 0", busy_o); end
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
    @(negedge clk_i);
    send_frame(32'hFF, 8);
    @(negedge clk_i);
    checks++; if (deser_data_val_o !== 1'b1) begin errors++; $display("FAIL mid_next_val got %b exp 1", deser_data_val_o); end
    checks++; if (deser_data_o !== 16'hFF00) begin errors++; $display("FAIL mid_next_data got %h exp ff00", deser_data_o); end
    checks++; if (deser_data_mod_o !== 4'd8) begin errors++; $display("FAIL mid_next_mod got %0d exp 8", deser_data_mod_o); end
    @(negedge clk_i);
    checks++; if (val_cnt !== 1) begin errors++; $display("FAIL mid_pulses got %0d exp 1", val_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL mid_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL excl_val_err got %0d exp 0", both_cnt); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    both_cnt = 0;
    clear_counts();
    test_reset();
    test_full_frame();
    test_short_good();
    test_too_short();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
